// File: rtl/loop_nest_sequencer.sv
// ---------------------------------------------------------------------------
// loop_nest_sequencer
//
// Control FSM for up to three nested loops (i outer, j middle, k inner) that
// run on three external loop-counter registers. The counters are cleared and
// incremented through one-cycle strobes, and each one reports a compare flag
// z = (limit <= count). Every loop-body iteration is handed to the ALU
// micro-sequencer through the body_req/body_ack handshake.
//
// Handshake: body_req is a level that is high for the whole of BODY.
// A body iteration completes on the first rising Clk edge where both
// body_req and body_ack are high. body_ack may already be high in the first
// BODY cycle, and it is ignored while body_req is low.
//
// Ports
//   Clk        in   clock, all state changes on posedge
//   RST        in   synchronous active-high reset, forces all outputs low
//   start      in   begin a sequence (sampled only in IDLE)
//   abort      in   cancel the sequence, back to IDLE with no done pulse
//   depth[1:0] in   1=k, 2=k,j, 3=k,j,i; 0 is treated as 1
//   cnt_z[2:0] in   counter z flags, [0]=k [1]=j [2]=i
//   body_ack   in   body iteration finished
//   cnt_rst    out  one-cycle clear strobes, same bit order as cnt_z
//   cnt_inc    out  one-cycle increment strobes
//   body_req   out  body iteration request (level)
//   busy       out  high in every state except IDLE
//   done       out  one-cycle completion pulse
//   iter_cnt   out  body handshakes completed since the last start
//   state_dbg  out  current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module loop_nest_sequencer #(
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          RST,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    depth,
    input  logic [2:0]    cnt_z,
    input  logic          body_ack,
    output logic [2:0]    cnt_rst,
    output logic [2:0]    cnt_inc,
    output logic          body_req,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] iter_cnt,
    output logic [3:0]    state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CLR   = 4'd1,
        S_CHK0  = 4'd2,
        S_BODY  = 4'd3,
        S_INC_K = 4'd4,
        S_CHK_K = 4'd5,
        S_INC_J = 4'd6,
        S_CHK_J = 4'd7,
        S_INC_I = 4'd8,
        S_CHK_I = 4'd9,
        S_DONE  = 4'd10
    } state_t;

    state_t     state, state_nx;
    logic [1:0] depth_q;
    logic       depth_ld;
    logic       iter_clr;
    logic       iter_inc;
    logic       use_j;
    logic       use_i;
    logic       zero_trip;

    // Ungated output values, forced low below during a reset cycle
    logic [2:0] cnt_rst_c;
    logic [2:0] cnt_inc_c;
    logic       body_req_c;
    logic       busy_c;
    logic       done_c;

    assign use_j     = depth_q[1];
    assign use_i     = (depth_q == 2'd3);
    // Unused levels still get cleared in CLR, but their z flags never count
    assign zero_trip = cnt_z[0] | (use_j & cnt_z[1]) | (use_i & cnt_z[2]);

    always_ff @(posedge Clk) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            depth_q <= 2'd1;
        end else if (depth_ld) begin
            depth_q <= (depth == 2'd0) ? 2'd1 : depth;
        end
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            iter_cnt <= '0;
        end else if (iter_clr) begin
            iter_cnt <= '0;
        end else if (iter_inc) begin
            iter_cnt <= iter_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_nx   = state;
        depth_ld   = 1'b0;
        iter_clr   = 1'b0;
        iter_inc   = 1'b0;
        cnt_rst_c  = 3'b000;
        cnt_inc_c  = 3'b000;
        body_req_c = 1'b0;
        busy_c     = 1'b1;
        done_c     = 1'b0;

        case (state)
            S_IDLE: begin
                busy_c = 1'b0;
                if (start) begin
                    depth_ld = 1'b1;
                    iter_clr = 1'b1;
                    state_nx = S_CLR;
                end
            end
            S_CLR: begin
                cnt_rst_c = 3'b111;
                state_nx  = S_CHK0;
            end
            S_CHK0: begin
                state_nx = zero_trip ? S_DONE : S_BODY;
            end
            S_BODY: begin
                body_req_c = 1'b1;
                if (body_ack) begin
                    iter_inc = 1'b1;
                    state_nx = S_INC_K;
                end
            end
            S_INC_K: begin
                cnt_inc_c[0] = 1'b1;
                state_nx     = S_CHK_K;
            end
            S_CHK_K: begin
                if (!cnt_z[0])  state_nx = S_BODY;
                else if (use_j) state_nx = S_INC_J;
                else            state_nx = S_DONE;
            end
            S_INC_J: begin
                // Step j and restart k in the same cycle
                cnt_inc_c[1] = 1'b1;
                cnt_rst_c[0] = 1'b1;
                state_nx     = S_CHK_J;
            end
            S_CHK_J: begin
                if (!cnt_z[1])  state_nx = S_BODY;
                else if (use_i) state_nx = S_INC_I;
                else            state_nx = S_DONE;
            end
            S_INC_I: begin
                cnt_inc_c[2] = 1'b1;
                cnt_rst_c[1] = 1'b1;
                state_nx     = S_CHK_I;
            end
            S_CHK_I: begin
                state_nx = cnt_z[2] ? S_DONE : S_BODY;
            end
            S_DONE: begin
                done_c   = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Abort keeps this cycle's outputs but cancels every side effect
        if (abort) begin
            state_nx = S_IDLE;
            depth_ld = 1'b0;
            iter_clr = 1'b0;
            iter_inc = 1'b0;
        end
    end

    // No strobes or status are presented while RST is high
    assign cnt_rst   = RST ? 3'b000 : cnt_rst_c;
    assign cnt_inc   = RST ? 3'b000 : cnt_inc_c;
    assign body_req  = RST ? 1'b0 : body_req_c;
    assign busy      = RST ? 1'b0 : busy_c;
    assign done      = RST ? 1'b0 : done_c;
    assign state_dbg = state;

endmodule

// File: tb/tb_loop_nest_sequencer.sv
// ---------------------------------------------------------------------------
// tb_loop_nest_sequencer
//
// Bench for loop_nest_sequencer. The three loop counters are modelled as
// plain registers with limits written by the stimulus. A responder answers
// body_req either with a tied-high ack or after a programmable delay.
// Expected counts and latencies come from loop arithmetic on the limits
// (product of the active limits, number of j/i steps, cycles per step).
// ---------------------------------------------------------------------------
module tb_loop_nest_sequencer;

    localparam int CW = 16;

    logic          Clk;
    logic          RST;
    logic          start;
    logic          abort;
    logic [1:0]    depth;
    logic [2:0]    cnt_z;
    logic          body_ack;
    logic [2:0]    cnt_rst;
    logic [2:0]    cnt_inc;
    logic          body_req;
    logic          busy;
    logic          done;
    logic [CW-1:0] iter_cnt;
    logic [3:0]    state_dbg;

    int n_checks = 0;
    int n_err    = 0;

    // Loop-counter model and ack responder controls
    int   cnt_v[3];
    int   lim[3];
    logic [2:0] force_z;
    logic ack_tie;
    int   ack_delay;
    int   ack_wait;

    loop_nest_sequencer #(.CW(CW)) dut (
        .Clk       (Clk),
        .RST       (RST),
        .start     (start),
        .abort     (abort),
        .depth     (depth),
        .cnt_z     (cnt_z),
        .body_ack  (body_ack),
        .cnt_rst   (cnt_rst),
        .cnt_inc   (cnt_inc),
        .body_req  (body_req),
        .busy      (busy),
        .done      (done),
        .iter_cnt  (iter_cnt),
        .state_dbg (state_dbg)
    );

    // Clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // External loop counters: clear wins, z compares limit against count
    always @(posedge Clk) begin
        for (int n = 0; n < 3; n++) begin
            if (cnt_rst[n])      cnt_v[n] <= 0;
            else if (cnt_inc[n]) cnt_v[n] <= cnt_v[n] + 1;
        end
    end

    always_comb begin
        cnt_z = 3'b000;
        for (int n = 0; n < 3; n++) begin
            cnt_z[n] = force_z[n] | (lim[n] <= cnt_v[n]);
        end
    end

    // Ack responder: tied high, or raised after ack_delay cycles of body_req
    initial begin
        body_ack = 1'b0;
        ack_wait = 0;
    end

    always @(posedge Clk) begin
        #1;
        if (ack_tie) begin
            body_ack = 1'b1;
        end else if (body_req) begin
            body_ack = (ack_wait >= ack_delay);
            ack_wait = ack_wait + 1;
        end else begin
            body_ack = 1'b0;
            ack_wait = 0;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One complete sequence from start to done, checked against loop arithmetic
    task automatic run_seq(input string tag, input int d, input int li,
                           input int lj, input int lk, input bit tie,
                           input int dly, input bit pulse_busy,
                           input bit start_in_done);
        int deff, b, nj, ni, exp_lat, lat_max;
        int c, got, done_c;
        int hs, req_c, inc0, inc1, inc2, rst0, rst1, ovl;

        deff = (d == 0) ? 1 : d;
        b = lk;
        if (deff >= 2) b = b * lj;
        if (deff == 3) b = b * li;
        // Every finished k pass steps j (including the last); same for i
        nj = (deff >= 2 && b > 0) ? ((deff == 3) ? li * lj : lj) : 0;
        ni = (deff == 3 && b > 0) ? li : 0;
        if (b == 0) exp_lat = 3;
        else        exp_lat = 2 + b * ((tie ? 0 : dly) + 1) + 2 * b + 2 * nj + 2 * ni + 1;
        lat_max = exp_lat + 20;

        @(negedge Clk);
        depth     = 2'(d);
        lim[0]    = lk;
        lim[1]    = lj;
        lim[2]    = li;
        ack_tie   = tie;
        ack_delay = dly;
        start     = 1'b1;

        c = 0; got = 0; done_c = 0;
        hs = 0; req_c = 0; inc0 = 0; inc1 = 0; inc2 = 0; rst0 = 0; rst1 = 0; ovl = 0;
        while (!got && c < lat_max) begin
            @(negedge Clk);
            c++;
            start = (pulse_busy && exp_lat > 6 && c == 4);
            if (c == 1) chk({tag, "_clr_all"}, int'(cnt_rst), 7);
            if ((cnt_rst & cnt_inc) !== 3'b000) ovl++;
            if (body_req === 1'b1 && body_ack === 1'b1) hs++;
            if (body_req === 1'b1) req_c++;
            if (cnt_inc[0]) inc0++;
            if (cnt_inc[1]) inc1++;
            if (cnt_inc[2]) inc2++;
            if (c > 1 && cnt_rst[0]) rst0++;
            if (c > 1 && cnt_rst[1]) rst1++;
            if (done === 1'b1) begin
                got    = 1;
                done_c = c;
                if (start_in_done) start = 1'b1;
            end
        end

        chk({tag, "_done_seen"}, got, 1);
        if (!got) begin
            // Recover a stuck DUT so the remaining steps can still run
            @(negedge Clk);
            RST = 1'b1;
            @(negedge Clk);
            RST = 1'b0;
        end else begin
            @(negedge Clk);
            start = 1'b0;
            chk({tag, "_busy_after"}, int'(busy), 0);
            chk({tag, "_done_one_cycle"}, int'(done), 0);
        end
        chk({tag, "_latency"}, done_c, exp_lat);
        chk({tag, "_iter_cnt"}, int'(iter_cnt), b % (1 << CW));
        chk({tag, "_handshakes"}, hs, b);
        chk({tag, "_req_cycles"}, req_c, b * ((tie ? 0 : dly) + 1));
        chk({tag, "_inc_k"}, inc0, b);
        chk({tag, "_inc_j"}, inc1, nj);
        chk({tag, "_inc_i"}, inc2, ni);
        chk({tag, "_rst_k"}, rst0, nj);
        chk({tag, "_rst_j"}, rst1, ni);
        chk({tag, "_no_overlap"}, ovl, 0);
    endtask

    initial begin
        int seen, quiet;

        RST       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        depth     = 2'd1;
        force_z   = 3'b000;
        ack_tie   = 1'b1;
        ack_delay = 0;
        for (int n = 0; n < 3; n++) lim[n] = 1;

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_strobes", int'({cnt_rst, cnt_inc}), 0);
        chk("rst_req_done", int'({body_req, done}), 0);
        RST = 1'b0;
        @(negedge Clk);
        chk("rst_iter", int'(iter_cnt), 0);
        chk("rst_idle_busy", int'(busy), 0);

        // T1: vector, 4 iterations, ack tied high
        run_seq("t1", 1, 0, 0, 4, 1'b1, 0, 1'b0, 1'b0);

        // T2: matrix-matrix 2x3x4 with a 2-cycle ack delay
        run_seq("t2", 3, 2, 3, 4, 1'b0, 2, 1'b1, 1'b0);

        // T3: zero-trip j; start held through DONE must be ignored there
        run_seq("t3", 2, 1, 0, 3, 1'b1, 0, 1'b0, 1'b1);

        // T4: reset in the middle of a depth-3 run
        @(negedge Clk);
        depth = 2'd3; lim[0] = 4; lim[1] = 3; lim[2] = 2; ack_tie = 1'b1; start = 1'b1;
        seen = 0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            @(negedge Clk);
            start = 1'b0;
            if (c > 10 && body_req === 1'b1) seen = 1;
        end
        chk("t4_in_body", seen, 1);
        RST = 1'b1;
        #1;
        chk("t4_rst_cycle_quiet", int'({cnt_rst, cnt_inc, body_req, busy, done}), 0);
        @(negedge Clk);
        RST = 1'b0;
        chk("t4_after_busy", int'(busy), 0);
        chk("t4_after_outs", int'({cnt_rst, cnt_inc, body_req, done}), 0);
        chk("t4_after_iter", int'(iter_cnt), 0);
        run_seq("t4_rerun", 3, 2, 3, 4, 1'b1, 0, 1'b0, 1'b0);

        // T5: abort in CHK_J of a depth-2 run, with a start pulse while busy
        @(negedge Clk);
        depth = 2'd2; lim[0] = 2; lim[1] = 3; lim[2] = 0; ack_tie = 1'b1; start = 1'b1;
        seen = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge Clk);
            start = (c == 4);
            if (cnt_inc[1]) seen = 1;
        end
        start = 1'b0;
        chk("t5_inc_j_seen", seen, 1);
        @(negedge Clk);
        abort = 1'b1;
        chk("t5_iter_at_chk_j", int'(iter_cnt), 2);
        @(negedge Clk);
        abort = 1'b0;
        chk("t5_abort_busy", int'(busy), 0);
        chk("t5_iter_held", int'(iter_cnt), 2);
        quiet = 1;
        repeat (5) begin
            @(negedge Clk);
            if (done !== 1'b0 || busy !== 1'b0) quiet = 0;
        end
        chk("t5_no_done", quiet, 1);
        chk("t5_iter_still_held", int'(iter_cnt), 2);

        // T6: depth 0 behaves as depth 1; a forced j flag must be ignored
        force_z = 3'b010;
        run_seq("t6", 0, 2, 2, 3, 1'b1, 0, 1'b0, 1'b0);
        force_z = 3'b000;

        // Randomized sequences
        for (int r = 0; r < 8; r++) begin
            run_seq($sformatf("rnd%0d", r), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 2)), 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
